// File: rtl/clk_div_tick.sv
// ---------------------------------------------------------------------------
// clk_div_tick
//
// Programmable clock-enable generator. Divides clk by (div_reg + 1) and emits
// single-cycle enables for the downstream timer and display logic.
//
// Parameters:
//   CNT_W       width of the main counter and the divisor register
//   DEFAULT_DIV divisor register value after reset (must be < 2**CNT_W)
//   SUB_DIV     ticks per sub_tick (>= 1)
//   SUB_W       width of the sub-stage counter (2**SUB_W >= SUB_DIV)
//
// Ports:
//   clk       in   system clock, all state updates on its rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   count enable; low pauses the main counter
//   div_load  in   strobe: load div_val into the divisor register
//   div_val   in   new terminal count (period = div_val + 1 cycles)
//   tick      out  registered one-cycle pulse, once per period
//   sub_tick  out  registered pulse coincident with every SUB_DIV-th tick
//   sq_out    out  registered square wave, toggles on every tick event
//   count     out  current main counter value
//
// Build option:
//   CLK_DIV_TICK_SUB_EN  when defined, the sub-stage counter and sub_tick are
//                        built; otherwise sub_tick is tied low.
// ---------------------------------------------------------------------------
module clk_div_tick #(
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 983040,
    parameter int SUB_DIV     = 10,
    parameter int SUB_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             tick,
    output logic             sub_tick,
    output logic             sq_out,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] div_reg,   div_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             tick_reg,  tick_next;
    logic             sq_reg,    sq_next;
    logic             tick_event;

    // A load takes priority over counting, so it suppresses the tick event.
    assign tick_event = en && !div_load && (count_reg == div_reg);

    always_comb begin
        div_next   = div_reg;
        count_next = count_reg;
        tick_next  = 1'b0;
        sq_next    = sq_reg;
        if (div_load) begin
            // Clearing count here keeps it from ending up above a smaller
            // terminal count.
            div_next   = div_val;
            count_next = '0;
        end else if (en) begin
            if (tick_event) begin
                count_next = '0;
                tick_next  = 1'b1;
                sq_next    = ~sq_reg;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg   <= CNT_W'(DEFAULT_DIV);
            count_reg <= '0;
            tick_reg  <= 1'b0;
            sq_reg    <= 1'b0;
        end else begin
            div_reg   <= div_next;
            count_reg <= count_next;
            tick_reg  <= tick_next;
            sq_reg    <= sq_next;
        end
    end

    assign tick   = tick_reg;
    assign sq_out = sq_reg;
    assign count  = count_reg;

`ifdef CLK_DIV_TICK_SUB_EN
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

    logic [SUB_W-1:0] sub_cnt_reg,  sub_cnt_next;
    logic             sub_tick_reg, sub_tick_next;

    always_comb begin
        sub_cnt_next  = sub_cnt_reg;
        sub_tick_next = 1'b0;
        if (div_load) begin
            sub_cnt_next = '0;
        end else if (tick_event) begin
            if (sub_cnt_reg == SUB_LAST) begin
                sub_cnt_next  = '0;
                sub_tick_next = 1'b1;
            end else begin
                sub_cnt_next = sub_cnt_reg + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_cnt_reg  <= '0;
            sub_tick_reg <= 1'b0;
        end else begin
            sub_cnt_reg  <= sub_cnt_next;
            sub_tick_reg <= sub_tick_next;
        end
    end

    assign sub_tick = sub_tick_reg;
`else
    // Sub-stage not built. The parameter check below keeps SUB_DIV/SUB_W
    // referenced so a misconfigured instance still elaborates identically.
    if (SUB_DIV < 1 || (2 ** SUB_W) < SUB_DIV) begin : g_sub_cfg_out_of_range
    end

    assign sub_tick = 1'b0;
`endif

endmodule
